// File: rtl/serial_to_parallel.sv
// serial_to_parallel
//   Bit-serial receiver. Gathers N consecutive bits from serial_in into a
//   parallel word, presents it on parallel_out with a one-cycle valid pulse,
//   and raises a sticky frame_err when start is asserted mid-frame.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; start edge samples bit #1 of the frame
//   RECV  | sampling bits #2..#N; the edge taking bit #N completes it
//
// Ports
//   clk           system clock, rising edge active
//   rst           asynchronous reset, active low
//   start         frame start, honoured only in IDLE
//   serial_in     serial data bit
//   parallel_out  last completed word, held until the next completion
//   valid         one-cycle pulse after parallel_out is updated
//   busy          high while a frame is in progress after its first bit
//   frame_err     sticky: start was seen while a frame was in progress
module serial_to_parallel #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         serial_in,
    output logic [N-1:0] parallel_out,
    output logic         valid,
    output logic         busy,
    output logic         frame_err
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [N-1:0]  shreg, shreg_nxt;
    logic [N-1:0]  shifted;
    logic [N-1:0]  pout_nxt;
    logic          valid_nxt;
    logic          busy_nxt;
    logic          err_nxt;

    // Assembly register with the current serial_in already inserted, so the
    // completing edge can publish the word including its final bit.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shifted = {serial_in, shreg[N-1:1]};
        end else begin : g_msb_first
            assign shifted = {shreg[N-2:0], serial_in};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        shreg_nxt = shreg;
        pout_nxt  = parallel_out;
        valid_nxt = 1'b0;
        busy_nxt  = busy;
        err_nxt   = frame_err;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt = shifted;
                    count_nxt = ONE_CNT;
                    busy_nxt  = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                shreg_nxt = shifted;
                // start mid-frame is only recorded; framing is not disturbed
                if (start) begin
                    err_nxt = 1'b1;
                end
                if (count == LAST_CNT) begin
                    pout_nxt  = shifted;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count + ONE_CNT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            shreg        <= '0;
            parallel_out <= '0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            shreg        <= shreg_nxt;
            parallel_out <= pout_nxt;
            valid        <= valid_nxt;
            busy         <= busy_nxt;
            frame_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel
//   Drives an LSB-first and an MSB-first receiver from the same serial line
//   and compares both against a frame-level reference model every cycle.
module tb_serial_to_parallel;

    localparam int N = 8;

    logic         clk       = 1'b0;
    logic         clk_en    = 1'b0;
    logic         rst       = 1'b0;
    logic         start     = 1'b0;
    logic         serial_in = 1'b0;

    logic [N-1:0] lsb_out, msb_out;
    logic         lsb_valid, msb_valid;
    logic         lsb_busy, msb_busy;
    logic         lsb_err, msb_err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int           m_cnt;
    bit           m_q[$];
    logic [N-1:0] m_lsb_out, m_msb_out;
    logic         m_valid, m_busy, m_err;

    always #5 if (clk_en) clk = ~clk;

    serial_to_parallel #(.N(N), .LSB_FIRST(1'b1)) u_lsb (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .serial_in    (serial_in),
        .parallel_out (lsb_out),
        .valid        (lsb_valid),
        .busy         (lsb_busy),
        .frame_err    (lsb_err)
    );

    serial_to_parallel #(.N(N), .LSB_FIRST(1'b0)) u_msb (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .serial_in    (serial_in),
        .parallel_out (msb_out),
        .valid        (msb_valid),
        .busy         (msb_busy),
        .frame_err    (msb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_q.delete();
        m_lsb_out = '0;
        m_msb_out = '0;
        m_valid   = 1'b0;
        m_busy    = 1'b0;
        m_err     = 1'b0;
    endtask

    // Expected outputs after one rising edge that samples start=s, serial_in=d.
    task automatic model_edge(input bit s, input bit d);
        m_valid = 1'b0;
        if (m_cnt == 0) begin
            if (s) begin
                m_q.delete();
                m_q.push_back(d);
                m_cnt  = 1;
                m_busy = 1'b1;
            end
        end else begin
            if (s) m_err = 1'b1;
            m_q.push_back(d);
            m_cnt++;
            if (m_cnt == N) begin
                // received bit #k+1 lands in bit k (LSB first) or bit N-1-k
                foreach (m_q[k]) begin
                    m_lsb_out[k]       = m_q[k];
                    m_msb_out[N-1-k]   = m_q[k];
                end
                m_valid = 1'b1;
                m_busy  = 1'b0;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("lsb_out",   32'(lsb_out),   32'(m_lsb_out));
        chk("lsb_valid", 32'(lsb_valid), 32'(m_valid));
        chk("lsb_busy",  32'(lsb_busy),  32'(m_busy));
        chk("lsb_err",   32'(lsb_err),   32'(m_err));
        chk("msb_out",   32'(msb_out),   32'(m_msb_out));
        chk("msb_valid", 32'(msb_valid), 32'(m_valid));
        chk("msb_busy",  32'(msb_busy),  32'(m_busy));
        chk("msb_err",   32'(msb_err),   32'(m_err));
    endtask

    // Called at a falling edge: drive inputs, advance the model across the
    // next rising edge, then compare at the following falling edge.
    task automatic step(input bit s, input bit d);
        start     = s;
        serial_in = d;
        model_edge(s, d);
        @(negedge clk);
        check_all();
    endtask

    // Transmit w bit 0 first; glitch >= 1 re-asserts start on that bit index.
    task automatic send_word(input logic [N-1:0] w, input int glitch, output int busy_cycles);
        busy_cycles = 0;
        for (int k = 0; k < N; k++) begin
            step((k == 0) || (k == glitch), w[k]);
            if (lsb_busy) busy_cycles++;
        end
        start = 1'b0;
    endtask

    task automatic async_reset();
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int bc;

        // reset with no clock running
        model_reset();
        #10;
        chk("rst_lsb_out",   32'(lsb_out),   32'h0);
        chk("rst_lsb_valid", 32'(lsb_valid), 32'h0);
        chk("rst_lsb_busy",  32'(lsb_busy),  32'h0);
        chk("rst_lsb_err",   32'(lsb_err),   32'h0);
        chk("rst_msb_out",   32'(msb_out),   32'h0);
        chk("rst_msb_valid", 32'(msb_valid), 32'h0);
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // basic frame, then zero-gap back-to-back frame
        send_word(8'hAB, 0, bc);
        chk("basic_word",  32'(lsb_out),   32'hAB);
        chk("basic_valid", 32'(lsb_valid), 32'h1);
        chk("msb_word",    32'(msb_out),   32'hD5);
        chk("basic_busy_cycles", 32'(bc),  32'd7);
        send_word(8'h5C, 0, bc);
        chk("b2b_word",  32'(lsb_out),   32'h5C);
        chk("b2b_valid", 32'(lsb_valid), 32'h1);
        step(1'b0, 1'b1);
        chk("valid_one_cycle", 32'(lsb_valid), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));
        chk("word_held", 32'(lsb_out), 32'h5C);

        // start mid-frame: word unaffected, error sticky
        send_word(8'hAB, 3, bc);
        chk("ferr_word", 32'(lsb_out), 32'hAB);
        chk("ferr_flag", 32'(lsb_err), 32'h1);
        send_word(8'h3C, 0, bc);
        chk("ferr_sticky", 32'(lsb_err), 32'h1);

        // reset mid-frame, then a full all-ones frame
        step(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(k == 0, 1'b1);
        async_reset();
        chk("midrst_busy", 32'(lsb_busy), 32'h0);
        chk("midrst_err",  32'(lsb_err),  32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        chk("midrst_no_valid", 32'(lsb_valid), 32'h0);
        send_word(8'hFF, 0, bc);
        chk("ff_word",  32'(lsb_out),   32'hFF);
        chk("ff_valid", 32'(lsb_valid), 32'h1);

        // randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
